// File: rtl/cache_retire_tracker.sv
// Per-entry INVALID -> VALID -> RETIRED -> INVALID lifecycle tracker with a retire
// deadline, a registered single-cycle error report and a saturating error count.
module cache_retire_tracker #(
    parameter int DEPTH   = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_en,
    input  logic [AW-1:0]     fill_addr,
    input  logic              retire_en,
    input  logic [AW-1:0]     retire_addr,
    input  logic              inval_en,
    input  logic [AW-1:0]     inval_addr,
    output logic [DEPTH-1:0]  valid_vec,
    output logic [DEPTH-1:0]  retired_vec,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [AW-1:0]     err_addr,
    output logic [CNTW-1:0]   err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

    localparam logic [2:0] ERR_NONE              = 3'd0;
    localparam logic [2:0] ERR_FILL_BUSY         = 3'd1;
    localparam logic [2:0] ERR_RETIRE_NOT_VALID  = 3'd2;
    localparam logic [2:0] ERR_INVAL_NOT_RETIRED = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT           = 3'd4;
    localparam logic [2:0] ERR_BAD_ADDR          = 3'd5;

    typedef enum logic [1:0] {
        ST_INVALID = 2'b00,
        ST_VALID   = 2'b01,
        ST_RETIRED = 2'b10
    } entry_state_e;

    entry_state_e       state_q [DEPTH];
    entry_state_e       state_d [DEPTH];
    logic [TW-1:0]      cnt_q   [DEPTH];
    logic [TW-1:0]      cnt_d   [DEPTH];

    logic [DEPTH-1:0]   fill_err;
    logic [DEPTH-1:0]   retire_err;
    logic [DEPTH-1:0]   inval_err;
    logic [DEPTH-1:0]   timeout_err;
    logic [DEPTH-1:0]   valid_d;
    logic [DEPTH-1:0]   retired_d;

    logic [2:0]         err_code_d;
    logic [AW-1:0]      err_addr_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic [AW-1:0] lowest(input logic [DEPTH-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = AW'(i);
            end
        end
        return r;
    endfunction

    // Same-address commands chain fill -> retire -> inval on a working copy of the
    // entry state; the deadline only fires if the entry was and still is VALID.
    always_comb begin
        entry_state_e s;
        logic         was_valid;
        logic         hit_f;
        logic         hit_r;
        logic         hit_i;

        fill_err    = '0;
        retire_err  = '0;
        inval_err   = '0;
        timeout_err = '0;
        valid_d     = '0;
        retired_d   = '0;

        for (int i = 0; i < DEPTH; i++) begin
            hit_f = fill_en   && (fill_addr   == AW'(i));
            hit_r = retire_en && (retire_addr == AW'(i));
            hit_i = inval_en  && (inval_addr  == AW'(i));

            case (state_q[i])
                ST_VALID:   s = ST_VALID;
                ST_RETIRED: s = ST_RETIRED;
                default:    s = ST_INVALID;
            endcase
            was_valid = (s == ST_VALID);

            if (hit_f) begin
                if (s == ST_INVALID) s = ST_VALID;
                else                 fill_err[i] = 1'b1;
            end
            if (hit_r) begin
                if (s == ST_VALID) s = ST_RETIRED;
                else               retire_err[i] = 1'b1;
            end
            if (hit_i) begin
                if (s == ST_RETIRED) s = ST_INVALID;
                else                 inval_err[i] = 1'b1;
            end

            cnt_d[i] = '0;
            if (was_valid && (s == ST_VALID)) begin
                if (cnt_q[i] == LAST_CNT) begin
                    s              = ST_RETIRED;
                    timeout_err[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            state_d[i]   = s;
            valid_d[i]   = (s == ST_VALID);
            retired_d[i] = (s == ST_RETIRED);
        end
    end

    always_comb begin
        logic          bad_hit;
        logic [AW-1:0] bad_addr;

        bad_hit  = 1'b0;
        bad_addr = '1;
        if (fill_en && !in_range(fill_addr)) begin
            bad_hit = 1'b1;
            if (fill_addr < bad_addr) bad_addr = fill_addr;
        end
        if (retire_en && !in_range(retire_addr)) begin
            bad_hit = 1'b1;
            if (retire_addr < bad_addr) bad_addr = retire_addr;
        end
        if (inval_en && !in_range(inval_addr)) begin
            bad_hit = 1'b1;
            if (inval_addr < bad_addr) bad_addr = inval_addr;
        end

        err_code_d = ERR_NONE;
        err_addr_d = '0;
        if (bad_hit) begin
            err_code_d = ERR_BAD_ADDR;
            err_addr_d = bad_addr;
        end else if (|timeout_err) begin
            err_code_d = ERR_TIMEOUT;
            err_addr_d = lowest(timeout_err);
        end else if (|inval_err) begin
            err_code_d = ERR_INVAL_NOT_RETIRED;
            err_addr_d = lowest(inval_err);
        end else if (|retire_err) begin
            err_code_d = ERR_RETIRE_NOT_VALID;
            err_addr_d = lowest(retire_err);
        end else if (|fill_err) begin
            err_code_d = ERR_FILL_BUSY;
            err_addr_d = lowest(fill_err);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_INVALID;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_vec   <= '0;
            retired_vec <= '0;
            err_valid   <= 1'b0;
            err_code    <= ERR_NONE;
            err_addr    <= '0;
            err_count   <= '0;
        end else begin
            valid_vec   <= valid_d;
            retired_vec <= retired_d;
            err_valid   <= (err_code_d != ERR_NONE);
            err_code    <= err_code_d;
            err_addr    <= err_addr_d;
            if ((err_code_d != ERR_NONE) && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_retire_tracker.sv
// Bench for cache_retire_tracker: a 4-entry instance and a 5-entry instance (short
// deadline, 2-bit count) checked against a cycle-stamped lifecycle model.
`timescale 1ns/1ps
module tb_cache_retire_tracker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, TIMEOUT=16, CNTW=8
    logic       fe_a, re_a, ie_a;
    logic [1:0] fa_a, ra_a, ia_a;
    logic [3:0] vv_a, rv_a;
    logic       ev_a;
    logic [2:0] ec_a;
    logic [1:0] ea_a;
    logic [7:0] cnt_a;

    // Instance B: DEPTH=5, TIMEOUT=4, CNTW=2
    logic       fe_b, re_b, ie_b;
    logic [2:0] fa_b, ra_b, ia_b;
    logic [4:0] vv_b, rv_b;
    logic       ev_b;
    logic [2:0] ec_b;
    logic [2:0] ea_b;
    logic [1:0] cnt_b;

    cache_retire_tracker #(.DEPTH(4), .AW(2), .TIMEOUT(16), .CNTW(8)) dut_a (
        .clk(clk), .reset(reset),
        .fill_en(fe_a), .fill_addr(fa_a), .retire_en(re_a), .retire_addr(ra_a),
        .inval_en(ie_a), .inval_addr(ia_a),
        .valid_vec(vv_a), .retired_vec(rv_a), .err_valid(ev_a), .err_code(ec_a),
        .err_addr(ea_a), .err_count(cnt_a)
    );

    cache_retire_tracker #(.DEPTH(5), .AW(3), .TIMEOUT(4), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset),
        .fill_en(fe_b), .fill_addr(fa_b), .retire_en(re_b), .retire_addr(ra_b),
        .inval_en(ie_b), .inval_addr(ia_b),
        .valid_vec(vv_b), .retired_vec(rv_b), .err_valid(ev_b), .err_code(ec_b),
        .err_addr(ea_b), .err_count(cnt_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: entry state 0=INVALID 1=VALID 2=RETIRED, plus the edge
    // number at which each entry last became VALID.
    int p_depth[2] = '{4, 5};
    int p_to[2]    = '{16, 4};
    int p_cmax[2]  = '{255, 3};
    int m_st[2][8];
    int m_since[2][8];
    int m_cnt[2];
    int m_code[2];
    int m_addr[2];
    int edge_no = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 8; e++) begin
                m_st[k][e]    = 0;
                m_since[k][e] = 0;
            end
            m_cnt[k]  = 0;
            m_code[k] = 0;
            m_addr[k] = 0;
        end
    endtask

    task automatic note(inout int bc, inout int ba, input int c, input int a);
        if (c > bc || (c == bc && a < ba)) begin
            bc = c;
            ba = a;
        end
    endtask

    task automatic model_step(input int k, input bit fe, input int fa, input bit re,
                              input int ra, input bit ie, input int ia);
        int bc, ba, s;
        bc = 0;
        ba = 0;
        if (fe && fa >= p_depth[k]) note(bc, ba, 5, fa);
        if (re && ra >= p_depth[k]) note(bc, ba, 5, ra);
        if (ie && ia >= p_depth[k]) note(bc, ba, 5, ia);
        for (int e = 0; e < p_depth[k]; e++) begin
            s = m_st[k][e];
            if (fe && fa == e) begin
                if (s == 0) begin
                    s = 1;
                    m_since[k][e] = edge_no;
                end else note(bc, ba, 1, e);
            end
            if (re && ra == e) begin
                if (s == 1) s = 2;
                else note(bc, ba, 2, e);
            end
            if (ie && ia == e) begin
                if (s == 2) s = 0;
                else note(bc, ba, 3, e);
            end
            if (s == 1 && m_st[k][e] == 1 && edge_no - m_since[k][e] == p_to[k]) begin
                s = 2;
                note(bc, ba, 4, e);
            end
            m_st[k][e] = s;
        end
        m_code[k] = bc;
        m_addr[k] = ba;
        if (bc != 0 && m_cnt[k] < p_cmax[k]) m_cnt[k]++;
    endtask

    function automatic int exp_vec(input int k, input int st);
        int v = 0;
        for (int e = 0; e < p_depth[k]; e++) begin
            if (m_st[k][e] == st) v |= (1 << e);
        end
        return v;
    endfunction

    task automatic check_fields(input string nm, input int av, input int ar, input int ae,
                                input int ac, input int aa, input int an, input int xv,
                                input int xr, input int xe, input int xc, input int xa,
                                input int xn);
        bit bad;
        n_cmp++;
        bad = (av != xv) || (ar != xr) || (ae != xe) || (an != xn) ||
              (xe != 0 && (ac != xc || aa != xa));
        if (bad) begin
            n_fail++;
            $display("FAIL %s @%0t: got valid=%0h retired=%0h err=%0d code=%0d addr=%0d count=%0d, want valid=%0h retired=%0h err=%0d code=%0d addr=%0d count=%0d",
                     nm, $time, av, ar, ae, ac, aa, an, xv, xr, xe, xc, xa, xn);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input int xv, input int xr, input int xe,
                         input int xc, input int xa, input int xn);
        check_fields(nm, int'(vv_a), int'(rv_a), int'(ev_a), int'(ec_a), int'(ea_a),
                     int'(cnt_a), xv, xr, xe, xc, xa, xn);
    endtask

    task automatic chk_b(input string nm, input int xv, input int xr, input int xe,
                         input int xc, input int xa, input int xn);
        check_fields(nm, int'(vv_b), int'(rv_b), int'(ev_b), int'(ec_b), int'(ea_b),
                     int'(cnt_b), xv, xr, xe, xc, xa, xn);
    endtask

    task automatic check_model();
        chk_a("model_a", exp_vec(0, 1), exp_vec(0, 2), int'(m_code[0] != 0), m_code[0],
              m_addr[0], m_cnt[0]);
        chk_b("model_b", exp_vec(1, 1), exp_vec(1, 2), int'(m_code[1] != 0), m_code[1],
              m_addr[1], m_cnt[1]);
    endtask

    task automatic idle();
        fe_a = 0; fa_a = '0; re_a = 0; ra_a = '0; ie_a = 0; ia_a = '0;
        fe_b = 0; fa_b = '0; re_b = 0; ra_b = '0; ie_b = 0; ia_b = '0;
    endtask

    // One clock: the model consumes the inputs the DUTs sample, outputs are checked
    // on the falling edge, and the caller drives the next inputs after that.
    task automatic cycle();
        @(posedge clk);
        edge_no++;
        model_step(0, fe_a, int'(fa_a), re_a, int'(ra_a), ie_a, int'(ia_a));
        model_step(1, fe_b, int'(fa_b), re_b, int'(ra_b), ie_b, int'(ia_b));
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit fe; int fa; bit re; int ra; bit ie; int ia;
        int xv; int xr; int xe; int xc; int xa; int xn;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 2, 0, 0, 0, 0, 'b0100, 0,       0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 'b0100, 0,       0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 'b0100, 0,       0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 'b0100, 0,       0, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 2, 0, 0, 0,      'b0100,  0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0,      'b0100,  0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,      'b0100,  0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 2, 0,      0,       0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 0,      0,       1, 2, 0, 1};
        tbl[9]  = '{1, 3, 0, 0, 0, 0, 'b1000, 0,       0, 0, 0, 1};
        tbl[10] = '{1, 3, 0, 0, 0, 0, 'b1000, 0,       1, 1, 3, 2};
        tbl[11] = '{0, 0, 0, 0, 1, 3, 'b1000, 0,       1, 3, 3, 3};
        tbl[12] = '{1, 2, 1, 2, 1, 2, 'b1000, 0,       0, 0, 0, 3};
        tbl[13] = '{0, 0, 1, 1, 1, 1, 'b1000, 0,       1, 3, 1, 4};
        tbl[14] = '{1, 0, 1, 3, 1, 1, 'b0001, 'b1000,  1, 3, 1, 5};
        tbl[15] = '{1, 3, 1, 0, 1, 3, 0,      'b0001,  1, 1, 3, 6};
        tbl[16] = '{0, 0, 0, 0, 1, 0, 0,      0,       0, 0, 0, 6};

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_a("reset_state_a", 0, 0, 0, 0, 0, 0);
        chk_b("reset_state_b", 0, 0, 0, 0, 0, 0);
        check_val("reset_code_a", int'(ec_a), 0);
        check_val("reset_addr_a", int'(ea_a), 0);

        // Directed vectors on instance A.
        for (int r = 0; r < 17; r++) begin
            idle();
            fe_a = tbl[r].fe; fa_a = 2'(tbl[r].fa);
            re_a = tbl[r].re; ra_a = 2'(tbl[r].ra);
            ie_a = tbl[r].ie; ia_a = 2'(tbl[r].ia);
            cycle();
            chk_a($sformatf("vec%0d", r), tbl[r].xv, tbl[r].xr, tbl[r].xe, tbl[r].xc,
                  tbl[r].xa, tbl[r].xn);
        end

        // Retire deadline on entry 1 of A.
        idle(); fe_a = 1; fa_a = 2'd1; cycle();
        idle();
        repeat (15) cycle();
        chk_a("to_before", 'b0010, 0, 0, 0, 0, 6);
        cycle();
        chk_a("to_fire", 0, 'b0010, 1, 4, 1, 7);
        cycle();
        chk_a("to_after", 0, 'b0010, 0, 0, 0, 7);
        ie_a = 1; ia_a = 2'd1; cycle();
        idle();

        // Retire landing on the deadline edge is a legal retire.
        fe_a = 1; fa_a = 2'd1; cycle();
        idle();
        repeat (15) cycle();
        re_a = 1; ra_a = 2'd1; cycle();
        chk_a("to_retire_race", 0, 'b0010, 0, 0, 0, 7);
        idle(); ie_a = 1; ia_a = 2'd1; cycle();
        idle();

        // Instance B: count saturation and out-of-range addresses.
        re_b = 1; ra_b = 3'd0;
        repeat (5) cycle();
        chk_b("sat", 0, 0, 1, 2, 0, 3);
        idle(); fe_b = 1; fa_b = 3'd6; re_b = 1; ra_b = 3'd1; cycle();
        chk_b("bad_addr", 0, 0, 1, 5, 6, 3);
        idle(); fe_b = 1; fa_b = 3'd7; re_b = 1; ra_b = 3'd5; cycle();
        chk_b("bad_addr_tie", 0, 0, 1, 5, 5, 3);
        idle();

        // Asynchronous reset with live entries and commands held during reset.
        fe_a = 1; fa_a = 2'd0; fe_b = 1; fa_b = 3'd1; cycle();
        fa_a = 2'd2; fe_b = 0; cycle();
        fe_a = 1; fa_a = 2'd3; re_a = 1; ra_a = 2'd0; fe_b = 1; fa_b = 3'd2;
        #2 reset = 1'b1;
        #1;
        chk_a("rst_async_a", 0, 0, 0, 0, 0, 0);
        chk_b("rst_async_b", 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        model_reset();
        cycle();
        chk_a("rst_release_a", 0, 0, 0, 0, 0, 0);
        chk_b("rst_release_b", 0, 0, 0, 0, 0, 0);
        fe_a = 1; fa_a = 2'd3; cycle();
        chk_a("first_cmd", 'b1000, 0, 0, 0, 0, 0);
        idle();

        // Random traffic on both instances against the model.
        for (int c = 0; c < 800; c++) begin
            fe_a = ($urandom_range(0, 99) < 40);
            fa_a = 2'($urandom_range(0, 3));
            re_a = ($urandom_range(0, 99) < 30);
            ra_a = 2'($urandom_range(0, 3));
            ie_a = ($urandom_range(0, 99) < 35);
            ia_a = 2'($urandom_range(0, 3));
            fe_b = ($urandom_range(0, 99) < 40);
            fa_b = 3'($urandom_range(0, 7));
            re_b = ($urandom_range(0, 99) < 25);
            ra_b = 3'($urandom_range(0, 7));
            ie_b = ($urandom_range(0, 99) < 35);
            ia_b = 3'($urandom_range(0, 7));
            cycle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
